soc_system_sysid_checker: RTL
=============================

# soc_system_sysid_checker

Avalon-MM read initiator that reads the system ID word (address 0) and build timestamp word (address 1) from the sysid control slave. It compares both against expected values and reports match or timeout status. It sits beside the sysid slave in soc_system and gives FPGA-side logic a hardware/software build-consistency check without involving the HPS.

## Interface
Parameters:
- EXPECTED_ID, 32'hACD51302, expected word at address 0
- EXPECTED_TIMESTAMP, 32'h61C57CEA, expected word at address 1
- USE_READDATAVALID, 0, 0 = fixed read latency 0 (data sampled in the acceptance cycle); 1 = data qualified by avm_readdatavalid
- TIMEOUT_CYCLES, 1024, maximum cycles per transaction (range 2..65535)

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run a check; ignored while busy=1
- avm_address  out  1  word address: 0 = ID, 1 = timestamp
- avm_read  out  1  read command
- avm_waitrequest  in  1  slave stall; tie 0 for the sysid slave
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  data qualifier; used only if USE_READDATAVALID=1
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when results are valid
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

## Operation
- State machine states: IDLE, ID_CMD, ID_RSP, TS_CMD, TS_RSP, REPORT.
- IDLE: on start=1, go to ID_CMD.
  - Clear id_ok, ts_ok, timeout, id_value, ts_value.
  - Clear the timeout counter.
- ID_CMD: avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
  - The command is accepted in the cycle where avm_read=1 and avm_waitrequest=0.
  - USE_READDATAVALID=0: capture avm_readdata into id_value on acceptance, then go to TS_CMD.
  - USE_READDATAVALID=1: go to ID_RSP on acceptance.
- ID_RSP: avm_read=0. On avm_readdatavalid=1, capture id_value and go to TS_CMD.
- TS_CMD / TS_RSP: same as ID_CMD / ID_RSP, but avm_address=1 and data is captured into ts_value. Then go to REPORT.
- REPORT: done=1 for exactly one cycle, then go to IDLE.
  - id_ok and ts_ok are registered comparisons, valid in the done cycle.
- Results hold until the next accepted start.
- Timeout:
  - A 16-bit counter is cleared on entry to each CMD state and increments every cycle in the CMD/RSP states.
  - When it reaches TIMEOUT_CYCLES-1 without completing, the transaction is abandoned: avm_read drops the next cycle and timeout=1.
  - On timeout, any ok flag not yet decided stays 0, and the state goes to REPORT.
  - Abandoning a read held under waitrequest is an intentional recovery-only protocol exception.
- A stray avm_readdatavalid in IDLE, REPORT or a CMD state is ignored.
- busy=1 in every state except IDLE.

## Timing
- Reset values: every output is 0 (avm_address=0, avm_read=0, busy=0, done=0, all status and value registers 0).
- Reset asserted mid-operation aborts immediately to IDLE; no completion pulse follows.
- Best case, USE_READDATAVALID=0, waitrequest=0:
  - start sampled at cycle 0
  - ID read at cycle 1
  - timestamp read at cycle 2
  - done at cycle 3
- Each waitrequest cycle adds 1 cycle.
- USE_READDATAVALID=1 adds 1 cycle (the RSP state) plus the slave latency per read.
- avm_address and avm_read are registered outputs with no combinational path from inputs.
- start coincident with done is ignored (busy is still 1).

## Test plan
- Default parameters, responder returns 32'hACD51302 / 32'h61C57CEA with latency 0, pulse start → avm_read high at cycles 1–2 (address 0 then 1), done at cycle 3, id_ok=1, ts_ok=1, timeout=0.
- Responder returns ID 32'h00000001 → done with id_ok=0, ts_ok=1, id_value=32'h00000001.
- avm_waitrequest high for 5 cycles on the ID read → avm_read and avm_address=0 stable throughout, done at cycle 8, both ok flags set.
- USE_READDATAVALID=1, readdatavalid 3 cycles after each acceptance → correct capture; a stray readdatavalid injected in IDLE changes no output.
- TIMEOUT_CYCLES=16, waitrequest stuck high → avm_read deasserts after 16 cycles, timeout=1, id_ok=0, ts_ok=0, done pulses once.
- reset_n asserted during TS_RSP → all outputs 0 asynchronously, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/soc_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// soc_system_sysid_checker
//
// Avalon-MM read initiator that fetches the system ID word (address 0) and
// the build timestamp word (address 1) from the sysid control slave. It
// compares both against the values this FPGA image was built with and
// reports match / timeout status. FPGA-side logic can use it to check that
// the hardware and software builds agree without going through the HPS.
//
// Ports
//    clock              system clock, rising edge
//    reset_n            asynchronous active-low reset
//    start              one-cycle request to run a check (ignored while busy)
//    avm_address        word address: 0 = ID, 1 = timestamp (registered)
//    avm_read           read command (registered)
//    avm_waitrequest    slave stall
//    avm_readdata       read data
//    avm_readdatavalid  data qualifier (only used when USE_READDATAVALID=1)
//    busy               check in progress
//    done               one-cycle pulse when results are valid
//    id_ok              captured ID equals EXPECTED_ID
//    ts_ok              captured timestamp equals EXPECTED_TIMESTAMP
//    timeout            a transaction ran out of cycles and was abandoned
//    id_value           captured ID word
//    ts_value           captured timestamp word
// ---------------------------------------------------------------------------
module soc_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'hACD51302,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h61C57CEA,
   parameter bit          USE_READDATAVALID  = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {
      IDLE,
      ID_CMD,
      ID_RSP,
      TS_CMD,
      TS_RSP,
      REPORT
   } state_t;

   // Last counter value a transaction may still complete in.
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   logic [15:0] timer;
   logic        timer_expired;
   logic        capture_id;
   logic        capture_ts;
   logic        abandon;
   logic        start_check;

   assign timer_expired = (timer == TIMER_LAST);
   assign start_check   = (state == IDLE) && start;

   // State register. Reset drops straight back to IDLE from anywhere, so an
   // interrupted check never produces a completion pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A completing transaction always wins over the
   // timeout, so a read finishing in the very last allowed cycle counts.
   // Without readdatavalid the data is taken in the acceptance cycle and the
   // RSP states are skipped entirely.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = ID_CMD;
            end
         end
         ID_CMD: begin
            if (!avm_waitrequest) begin
               next_state = USE_READDATAVALID ? ID_RSP : TS_CMD;
            end else if (timer_expired) begin
               next_state = REPORT;
            end
         end
         ID_RSP: begin
            if (avm_readdatavalid) begin
               next_state = TS_CMD;
            end else if (timer_expired) begin
               next_state = REPORT;
            end
         end
         TS_CMD: begin
            if (!avm_waitrequest) begin
               next_state = USE_READDATAVALID ? TS_RSP : REPORT;
            end else if (timer_expired) begin
               next_state = REPORT;
            end
         end
         TS_RSP: begin
            if (avm_readdatavalid) begin
               next_state = REPORT;
            end else if (timer_expired) begin
               next_state = REPORT;
            end
         end
         REPORT: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output / control decode. Capture strobes fire only in the state that
   // owns the data phase, which is what makes a stray readdatavalid in IDLE,
   // REPORT or a CMD state harmless.
   always_comb begin
      busy       = (state != IDLE);
      done       = (state == REPORT);
      capture_id = 1'b0;
      capture_ts = 1'b0;
      abandon    = 1'b0;
      case (state)
         ID_CMD: begin
            capture_id = !USE_READDATAVALID && !avm_waitrequest;
            abandon    = avm_waitrequest && timer_expired;
         end
         ID_RSP: begin
            capture_id = avm_readdatavalid;
            abandon    = !avm_readdatavalid && timer_expired;
         end
         TS_CMD: begin
            capture_ts = !USE_READDATAVALID && !avm_waitrequest;
            abandon    = avm_waitrequest && timer_expired;
         end
         TS_RSP: begin
            capture_ts = avm_readdatavalid;
            abandon    = !avm_readdatavalid && timer_expired;
         end
         default: begin
         end
      endcase
   end

   // Bus command registers, driven from the next state so avm_read/address
   // are clean flops with no combinational path from the slave's inputs.
   // The address stays at 1 through TS_RSP so it only moves between reads.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
      end else begin
         avm_read    <= (next_state == ID_CMD) || (next_state == TS_CMD);
         avm_address <= (next_state == TS_CMD) || (next_state == TS_RSP);
      end
   end

   // Per-transaction cycle counter: zeroed whenever a CMD state is entered
   // and counting through the CMD and RSP states of that transaction.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timer <= 16'd0;
      end else if (((next_state == ID_CMD) && (state != ID_CMD)) ||
                   ((next_state == TS_CMD) && (state != TS_CMD))) begin
         timer <= 16'd0;
      end else if (state inside {ID_CMD, ID_RSP, TS_CMD, TS_RSP}) begin
         timer <= timer + 16'd1;
      end else begin
         timer <= 16'd0;
      end
   end

   // Result registers. They are wiped only when a new check is accepted, so
   // the last outcome stays visible to the rest of the fabric. A flag whose
   // read was abandoned simply never gets set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         id_value <= 32'd0;
         ts_value <= 32'd0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
      end else if (start_check) begin
         id_value <= 32'd0;
         ts_value <= 32'd0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         if (capture_id) begin
            id_value <= avm_readdata;
            id_ok    <= (avm_readdata == EXPECTED_ID);
         end
         if (capture_ts) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
         end
         if (abandon) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule
